// File: rtl/lights_pkg.sv
// Shared types and constants for the light sequencer and its timer.
package lights_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WHITE  = 3'd1,
        ST_STEP   = 3'd2,
        ST_DWELL  = 3'd3,
        ST_MANUAL = 3'd4
    } state_e;

    localparam logic [2:0]  COLOUR_FIRST    = 3'd1;
    localparam logic [2:0]  COLOUR_LAST     = 3'd6;
    localparam int          STEPS_PER_CYCLE = 6;
    localparam logic [23:0] WHITE_RGB       = 24'hFFFFFF;

    // Colour index successor; anything outside 1..6 falls back to the first colour.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        if ((c >= COLOUR_LAST) || (c < COLOUR_FIRST)) begin
            return COLOUR_FIRST;
        end
        return c + 3'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter shared by the white, dwell and manual-timeout intervals.
module dwell_timer
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// Auto/manual controller for the lights selector. Define MAN_TIMEOUT_EN to bound
// manual grants to MAN_TIMEOUT cycles with a re-request lockout.
module light_sequencer
    import lights_pkg::*;
#(
    parameter int WHITE_CYCLES = 50,
    parameter int DWELL_CYCLES = 100,
    parameter int MAN_TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       man_req,
    input  logic       man_sel,
    input  logic       man_step,
    output logic       man_gnt,
    output logic       sel,
    output logic       button,
    output logic [2:0] colour_idx,
    output logic       cycle_done
);

    localparam int TMR_W = $clog2(max3(WHITE_CYCLES, DWELL_CYCLES, MAN_TIMEOUT) + 1);

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic       button_q, button_d;
    logic       gnt_q, gnt_d;
    logic       done_q, done_d;
    logic [2:0] colour_q, colour_d;
    logic [2:0] step_q, step_d;
    logic       man_step_q;
    logic       step_edge;
    logic       man_ok;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    assign step_edge = man_step && !man_step_q;

`ifdef MAN_TIMEOUT_EN
    logic lock_q, lock_d;

    // A revoked requester must release man_req before it can be granted again.
    always_comb begin
        lock_d = lock_q;
        if ((state_q == ST_MANUAL) && tmr_expired && man_req) begin
            lock_d = 1'b1;
        end
        if (!man_req) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign man_ok = man_req && !lock_q;
`else
    assign man_ok = man_req;
`endif

    function automatic state_e boundary_next(input state_e normal, input logic ok,
                                             input logic go);
        if (ok) begin
            return ST_MANUAL;
        end
        if (!go) begin
            return ST_IDLE;
        end
        return normal;
    endfunction

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        colour_d = colour_q;
        button_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (man_ok) begin
                    state_d = ST_MANUAL;
                end else if (run) begin
                    state_d = ST_WHITE;
                end
            end
            ST_WHITE: begin
                if (tmr_expired) begin
                    state_d = boundary_next(ST_STEP, man_ok, run);
                end
            end
            ST_STEP: begin
                state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (tmr_expired) begin
                    if (step_q == 3'(STEPS_PER_CYCLE)) begin
                        step_d  = '0;
                        done_d  = 1'b1;
                        state_d = boundary_next(ST_WHITE, man_ok, run);
                    end else begin
                        state_d = boundary_next(ST_STEP, man_ok, run);
                    end
                end
            end
            ST_MANUAL: begin
                // A step edge is honoured even in the cycle the requester lets go.
                if (step_edge) begin
                    button_d = 1'b1;
                    colour_d = next_colour(colour_q);
                end
                if (!man_req) begin
                    state_d = ST_IDLE;
`ifdef MAN_TIMEOUT_EN
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_STEP) && (state_q != ST_STEP)) begin
            button_d = 1'b1;
            colour_d = next_colour(colour_q);
            step_d   = step_q + 3'd1;
        end
        if (state_d == ST_IDLE) begin
            step_d = '0;
        end

        gnt_d = (state_d == ST_MANUAL);
        if (state_d == ST_MANUAL) begin
            sel_d = man_sel;
        end else begin
            sel_d = (state_d == ST_STEP) || (state_d == ST_DWELL);
        end
    end

    // The timer is reloaded on every state change with the new state's interval.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        unique case (state_d)
            ST_WHITE: tmr_val = TMR_W'(WHITE_CYCLES - 1);
            ST_DWELL: tmr_val = TMR_W'(DWELL_CYCLES - 1);
`ifdef MAN_TIMEOUT_EN
            ST_MANUAL: tmr_val = TMR_W'(MAN_TIMEOUT - 1);
`endif
            default: tmr_val = '0;
        endcase
    end

    dwell_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            button_q   <= 1'b0;
            gnt_q      <= 1'b0;
            done_q     <= 1'b0;
            colour_q   <= COLOUR_FIRST;
            step_q     <= '0;
            man_step_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            button_q   <= button_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            colour_q   <= colour_d;
            step_q     <= step_d;
            man_step_q <= man_step;
        end
    end

    assign sel        = sel_q;
    assign button     = button_q;
    assign man_gnt    = gnt_q;
    assign cycle_done = done_q;
    assign colour_idx = colour_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: expected button pulses and cycle_done pulses
// are queued by the stimulus and retired by a negedge monitor.
module tb_light_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       man_req;
    logic       man_sel;
    logic       man_step;
    logic       man_gnt;
    logic       sel;
    logic       button;
    logic [2:0] colour_idx;
    logic       cycle_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

`ifdef MAN_TIMEOUT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 10;
`endif

    typedef struct {
        int cyc;
        int colour;
        int sel;
    } ev_t;

    ev_t bq[$];
    int  dq[$];
    ev_t mon_ev;
    int  mon_dc;

    light_sequencer #(
        .WHITE_CYCLES (3),
        .DWELL_CYCLES (4),
        .MAN_TIMEOUT  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .man_req    (man_req),
        .man_sel    (man_sel),
        .man_step   (man_step),
        .man_gnt    (man_gnt),
        .sel        (sel),
        .button     (button),
        .colour_idx (colour_idx),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic push_btn(input int c, input int col);
        ev_t e;
        e.cyc    = c;
        e.colour = col;
        e.sel    = 1;
        bq.push_back(e);
    endtask

    // Monitor: every pulse must match the head of its queue.
    always @(negedge clk) begin
        if (button === 1'b1) begin
            if (bq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL button_unexpected: pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_ev = bq.pop_front();
                chk("button_cycle", cyc, mon_ev.cyc);
                chk("button_colour", {29'd0, colour_idx}, mon_ev.colour);
                chk("button_sel", {31'd0, sel}, mon_ev.sel);
            end
        end
        if (cycle_done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_dc = dq.pop_front();
                chk("done_cycle", cyc, mon_dc);
            end
        end
        chk("colour_in_range", {31'd0, (colour_idx >= 3'd1) && (colour_idx <= 3'd6)}, 1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3;
        rst = 1'b0; run = 1'b0; man_req = 1'b0; man_sel = 1'b0; man_step = 1'b0;
        wait_cyc(2);
        chk("rst_sel", sel, 0);
        chk("rst_button", button, 0);
        chk("rst_gnt", man_gnt, 0);
        chk("rst_done", cycle_done, 0);
        chk("rst_colour", colour_idx, 1);

        // Full auto cycle, then a second cycle stopped after colour 3.
        c0 = cyc;
        rst = 1'b1; run = 1'b1;
        for (int i = 0; i < 6; i++) push_btn(c0 + 4 + 5 * i, ((1 + i) % 6) + 1);
        dq.push_back(c0 + 34);
        push_btn(c0 + 37, 2);
        push_btn(c0 + 42, 3);
        wait_cyc(c0 + 1);  chk("white_sel_first", sel, 0);
        wait_cyc(c0 + 3);  chk("white_sel_last", sel, 0);
        wait_cyc(c0 + 5);  chk("dwell_sel", sel, 1);
        chk("dwell_button", button, 0);
        wait_cyc(c0 + 34); chk("restart_white_sel", sel, 0);
        wait_cyc(c0 + 44); run = 1'b0;
        wait_cyc(c0 + 46); chk("stop_dwell_sel", sel, 1);
        wait_cyc(c0 + 47); chk("stop_idle_sel", sel, 0);
        chk("stop_colour", colour_idx, 3);
        wait_cyc(c0 + 57);

        // Manual request raised mid-WHITE, granted at the WHITE boundary.
        c1 = cyc;
        run = 1'b1;
        push_btn(c1 + 6, 4);
        push_btn(c1 + 8, 5);
        wait_cyc(c1 + 1);  man_req = 1'b1;
        wait_cyc(c1 + 2);  chk("gnt_mid_white", man_gnt, 0);
        wait_cyc(c1 + 3);  chk("gnt_last_white", man_gnt, 0);
        wait_cyc(c1 + 4);  chk("gnt_at_boundary", man_gnt, 1);
        chk("man_sel_before", sel, 0);
        man_sel = 1'b1;
        wait_cyc(c1 + 5);  chk("man_sel_follow", sel, 1);
        man_step = 1'b1;
        wait_cyc(c1 + 6);  man_step = 1'b0;
        wait_cyc(c1 + 7);  man_step = 1'b1;
        wait_cyc(c1 + 8);  man_step = 1'b0;
        wait_cyc(c1 + 9);  man_req = 1'b0; run = 1'b0;
        wait_cyc(c1 + 10); chk("release_gnt", man_gnt, 0);
        chk("release_sel", sel, 0);
        chk("manual_colour", colour_idx, 5);
        wait_cyc(c1 + 12);

        // Held man_step gives one pulse; colour 6 wraps to 1.
        c2 = cyc;
        man_req = 1'b1;
        push_btn(c2 + 2, 6);
        push_btn(c2 + 4, 1);
        wait_cyc(c2 + 1);        chk("idle_grant", man_gnt, 1);
        man_step = 1'b1;
        wait_cyc(c2 + 2);        man_step = 1'b0;
        wait_cyc(c2 + 3);        man_step = 1'b1;
        wait_cyc(c2 + 3 + HOLD); chk("hold_gnt", man_gnt, 1);
        man_step = 1'b0; man_req = 1'b0;
        wait_cyc(c2 + 4 + HOLD); chk("hold_release_gnt", man_gnt, 0);
        chk("wrap_colour", colour_idx, 1);
        wait_cyc(c2 + 6 + HOLD);

        // Reset during STEP drops everything; auto restarts from WHITE.
        c3 = cyc;
        run = 1'b1;
        push_btn(c3 + 4, 2);
        wait_cyc(c3 + 4);  rst = 1'b0;
        wait_cyc(c3 + 5);  chk("midrst_button", button, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_colour", colour_idx, 1);
        chk("midrst_gnt", man_gnt, 0);
        rst = 1'b1;
        push_btn(c3 + 9, 2);
        wait_cyc(c3 + 6);  chk("restart_sel", sel, 0);
        wait_cyc(c3 + 9);  run = 1'b0;
        wait_cyc(c3 + 13); chk("restart_dwell_sel", sel, 1);
        wait_cyc(c3 + 14); chk("restart_idle_sel", sel, 0);
        chk("restart_colour", colour_idx, 2);
        wait_cyc(c3 + 16);

`ifdef MAN_TIMEOUT_EN
        begin
            int c4;
            c4 = cyc;
            man_req = 1'b1;
            wait_cyc(c4 + 1);  chk("to_gnt_first", man_gnt, 1);
            wait_cyc(c4 + 8);  chk("to_gnt_eighth", man_gnt, 1);
            wait_cyc(c4 + 9);  chk("to_revoked", man_gnt, 0);
            wait_cyc(c4 + 11); chk("to_locked", man_gnt, 0);
            man_req = 1'b0;
            wait_cyc(c4 + 12); man_req = 1'b1;
            wait_cyc(c4 + 13); chk("to_regrant", man_gnt, 1);
            man_req = 1'b0;
            wait_cyc(c4 + 14); chk("to_regrant_release", man_gnt, 0);
            wait_cyc(c4 + 16);
        end
`endif

        chk("button_queue_drained", bq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
